// File: rtl/regfile_tmr_scrub_pkg.sv
// Shared widths, scrubber state encoding and the bitwise 2-of-3 vote helper
// for the triple-redundant register file.
package mips_ft_pkg;
  localparam int NREG   = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FIX} scrub_state_e;

  function automatic logic [DATA_W-1:0] maj3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/regfile_tmr_scrub_if.sv
// Port bundle of the TMR register file: architectural read/write ports,
// scrubber control/status and the test-only fault-injection port.
interface regfile_tmr_scrub_if #(parameter int CNT_W = 16);
  import mips_ft_pkg::*;

  logic              we3;
  logic [ADDR_W-1:0] ra1, ra2, wa3;
  logic [DATA_W-1:0] wd3, rd1, rd2;
  logic              scrub_en;
  logic              inj_en;
  logic [1:0]        inj_copy;
  logic [ADDR_W-1:0] inj_addr;
  logic [DATA_W-1:0] inj_mask;
  logic [ADDR_W-1:0] scrub_addr;
  logic [CNT_W-1:0]  corr_count;
  logic              multi_fault;

  modport master (
    output we3, ra1, ra2, wa3, wd3, scrub_en, inj_en, inj_copy, inj_addr, inj_mask,
    input  rd1, rd2, scrub_addr, corr_count, multi_fault
  );

  modport slave (
    input  we3, ra1, ra2, wa3, wd3, scrub_en, inj_en, inj_copy, inj_addr, inj_mask,
    output rd1, rd2, scrub_addr, corr_count, multi_fault
  );
endinterface

// File: rtl/regfile_tmr_scrub_vote3.sv
// Bitwise 2-of-3 majority of three words plus a flag for "no two words equal".
module vote3 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] maj,
  output logic             all_differ
);
  assign maj        = (a & b) | (a & c) | (b & c);
  assign all_differ = (a != b) && (a != c) && (b != c);
endmodule

// File: rtl/regfile_tmr_scrub.sv
// Triple-redundant 3-port register file with voted reads and a background
// scrubber that rewrites the voted value into words whose copies disagree.
module regfile_tmr_scrub
  import mips_ft_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter bit INJ_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  regfile_tmr_scrub_if.slave  bus
);
  // Three distinct arrays keep synthesis from sharing storage between copies.
  logic [DATA_W-1:0] c0 [NREG];
  logic [DATA_W-1:0] c1 [NREG];
  logic [DATA_W-1:0] c2 [NREG];

  scrub_state_e      state;
  logic [ADDR_W-1:0] ptr, ptr_next, fix_addr;
  logic [DATA_W-1:0] fix_data;
  logic              abort_pend, fix_abort, fix_go;
  logic [CNT_W-1:0]  corr_count;
  logic              multi_fault;

  logic [NREG-1:0]      arch_hit, fix_hit;
  logic [2:0][NREG-1:0] inj_hit;

  logic [DATA_W-1:0] rd1_maj, rd2_maj, chk_maj;
  logic              chk_differ, chk_mismatch;
  logic              rd1_unused_differ, rd2_unused_differ;

  vote3 #(.WIDTH(DATA_W)) u_vote_rd1 (
    .a(c0[bus.ra1]), .b(c1[bus.ra1]), .c(c2[bus.ra1]),
    .maj(rd1_maj), .all_differ(rd1_unused_differ)
  );

  vote3 #(.WIDTH(DATA_W)) u_vote_rd2 (
    .a(c0[bus.ra2]), .b(c1[bus.ra2]), .c(c2[bus.ra2]),
    .maj(rd2_maj), .all_differ(rd2_unused_differ)
  );

  vote3 #(.WIDTH(DATA_W)) u_vote_chk (
    .a(c0[ptr]), .b(c1[ptr]), .c(c2[ptr]),
    .maj(chk_maj), .all_differ(chk_differ)
  );

  assign chk_mismatch = (c0[ptr] != c1[ptr]) || (c1[ptr] != c2[ptr]);
  assign ptr_next     = (ptr == ADDR_W'(NREG-1)) ? ADDR_W'(1) : ptr + ADDR_W'(1);

  assign bus.rd1         = (bus.ra1 == '0) ? '0 : rd1_maj;
  assign bus.rd2         = (bus.ra2 == '0) ? '0 : rd2_maj;
  assign bus.scrub_addr  = ptr;
  assign bus.corr_count  = corr_count;
  assign bus.multi_fault = multi_fault;

  // One-hot per-word write selects; priority is resolved in the storage block.
  always_comb begin
    arch_hit  = '0;
    fix_hit   = '0;
    inj_hit   = '0;
    fix_abort = abort_pend || (bus.we3 && (bus.wa3 == fix_addr));
    fix_go    = (state == S_FIX) && !fix_abort;
    if (bus.we3 && (bus.wa3 != '0))
      arch_hit[bus.wa3] = 1'b1;
    if (fix_go)
      fix_hit[fix_addr] = 1'b1;
    if (INJ_EN && bus.inj_en && (bus.inj_copy != 2'd3) && (bus.inj_addr != '0))
      inj_hit[bus.inj_copy][bus.inj_addr] = 1'b1;
  end

  // r0 is never written, so its copies stay at zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        c0[i] <= '0;
        c1[i] <= '0;
        c2[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (arch_hit[i]) begin
          c0[i] <= bus.wd3;
          c1[i] <= bus.wd3;
          c2[i] <= bus.wd3;
        end else if (fix_hit[i]) begin
          c0[i] <= fix_data;
          c1[i] <= fix_data;
          c2[i] <= fix_data;
        end else begin
          if (inj_hit[0][i]) c0[i] <= c0[i] ^ bus.inj_mask;
          if (inj_hit[1][i]) c1[i] <= c1[i] ^ bus.inj_mask;
          if (inj_hit[2][i]) c2[i] <= c2[i] ^ bus.inj_mask;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ptr         <= ADDR_W'(1);
      fix_addr    <= '0;
      fix_data    <= '0;
      abort_pend  <= 1'b0;
      corr_count  <= '0;
      multi_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.scrub_en) state <= S_CHECK;
        end
        S_CHECK: begin
          if (chk_differ) multi_fault <= 1'b1;
          if (chk_mismatch) begin
            fix_addr   <= ptr;
            fix_data   <= chk_maj;
            // A write landing on this word now already repaired it.
            abort_pend <= bus.we3 && (bus.wa3 == ptr);
            state      <= S_FIX;
          end else begin
            ptr   <= ptr_next;
            state <= bus.scrub_en ? S_CHECK : S_IDLE;
          end
        end
        S_FIX: begin
          if (!fix_abort && (corr_count != '1))
            corr_count <= corr_count + CNT_W'(1);
          abort_pend <= 1'b0;
          ptr        <= ptr_next;
          state      <= bus.scrub_en ? S_CHECK : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_tmr_scrub.sv
// Directed bench for the TMR register file: vector table for plain
// read/write, hand sequences for scrubbing, priority, reset and saturation.
module tb_regfile_tmr_scrub;
  import mips_ft_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_tmr_scrub_if #(.CNT_W(16)) bi ();
  regfile_tmr_scrub_if #(.CNT_W(2))  bs ();

  regfile_tmr_scrub #(.CNT_W(16), .INJ_EN(1'b1)) dut   (.clk(clk), .reset(rst_n), .bus(bi));
  regfile_tmr_scrub #(.CNT_W(2),  .INJ_EN(1'b1)) dut_s (.clk(clk), .reset(rst_n), .bus(bs));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [6];

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bi.we3 = 0; bi.wa3 = 0; bi.wd3 = 0; bi.ra1 = 0; bi.ra2 = 0; bi.scrub_en = 0;
    bi.inj_en = 0; bi.inj_copy = 0; bi.inj_addr = 0; bi.inj_mask = 0;
    bs.we3 = 0; bs.wa3 = 0; bs.wd3 = 0; bs.ra1 = 0; bs.ra2 = 0; bs.scrub_en = 0;
    bs.inj_en = 0; bs.inj_copy = 0; bs.inj_addr = 0; bs.inj_mask = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bi.we3 = 1; bi.wa3 = a; bi.wd3 = d;
    tick();
    bi.we3 = 0;
  endtask

  task automatic inj(input logic [1:0] cp, input logic [4:0] a, input logic [31:0] m);
    bi.inj_en = 1; bi.inj_copy = cp; bi.inj_addr = a; bi.inj_mask = m;
    tick();
    bi.inj_en = 0;
  endtask

  task automatic chk_copies(input string name, input int a, input logic [31:0] exp);
    chk({name, " c0"}, dut.c0[a], exp);
    chk({name, " c1"}, dut.c1[a], exp);
    chk({name, " c2"}, dut.c2[a], exp);
  endtask

  task automatic wait_fix(input string name);
    bit hit = 0;
    for (int n = 0; n < 60 && !hit; n++) begin
      if (dut.state == S_FIX) hit = 1;
      else tick();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: no fix cycle within 60 cycles", name);
    end
  endtask

  task automatic wait_count(input logic [15:0] target);
    for (int n = 0; n < 60 && bi.corr_count != target; n++) tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'h00000001, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd5,  32'hFFFFFFFF, 5'd5,  5'd31, 32'hDEADBEEF, 32'hA5A5A5A5};
    vecs[4] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd0,  32'h00000001, 32'h0};
    vecs[5] = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd1,  32'h12345678, 32'h00000001};

    do_reset();
    bi.ra1 = 5;
    #1;
    chk("reset rd1", bi.rd1, 32'h0);
    chk("reset scrub_addr", 32'(bi.scrub_addr), 32'd1);
    chk("reset corr_count", 32'(bi.corr_count), 32'd0);
    chk("reset multi_fault", 32'(bi.multi_fault), 32'd0);

    // Plain write/read table.
    for (int i = 0; i < 6; i++) begin
      bi.we3 = vecs[i].we; bi.wa3 = vecs[i].wa; bi.wd3 = vecs[i].wd;
      bi.ra1 = vecs[i].ra1; bi.ra2 = vecs[i].ra2;
      tick();
      bi.we3 = 0;
      chk($sformatf("vec%0d rd1", i), bi.rd1, vecs[i].exp1);
      chk($sformatf("vec%0d rd2", i), bi.rd2, vecs[i].exp2);
    end

    // Scrubber holds its pointer while disabled.
    tick(3);
    chk("idle scrub_addr", 32'(bi.scrub_addr), 32'd1);

    // Single-copy fault, masked on read, then corrected.
    do_reset();
    wr(5, 32'hDEADBEEF);
    inj(1, 5, 32'h1);
    bi.ra1 = 5;
    #1;
    chk("inj c1 raw", dut.c1[5], 32'hDEADBEEE);
    chk("inj rd1 voted", bi.rd1, 32'hDEADBEEF);
    bi.scrub_en = 1;
    wait_count(16'd1);
    chk("single corr_count", 32'(bi.corr_count), 32'd1);
    chk_copies("single fixed", 5, 32'hDEADBEEF);
    chk("single multi_fault", 32'(bi.multi_fault), 32'd0);

    // Every copy different: vote is still 0 bitwise, multi_fault latches.
    do_reset();
    wr(7, 32'h0);
    inj(0, 7, 32'h1);
    inj(1, 7, 32'h2);
    inj(2, 7, 32'h4);
    bi.ra1 = 7;
    #1;
    chk("multi rd1", bi.rd1, 32'h0);
    chk("multi mf before", 32'(bi.multi_fault), 32'd0);
    bi.scrub_en = 1;
    wait_count(16'd1);
    chk("multi corr_count", 32'(bi.corr_count), 32'd1);
    chk("multi mf after", 32'(bi.multi_fault), 32'd1);
    chk_copies("multi fixed", 7, 32'h0);

    // Architectural write in the fix cycle beats the scrub write.
    do_reset();
    wr(9, 32'hAAAA0000);
    inj(2, 9, 32'h000000FF);
    bi.ra1 = 9;
    bi.scrub_en = 1;
    wait_fix("prio fix");
    chk("prio fix addr", 32'(bi.scrub_addr), 32'd9);
    wr(9, 32'h12345678);
    tick(40);
    chk_copies("prio", 9, 32'h12345678);
    chk("prio rd1", bi.rd1, 32'h12345678);
    chk("prio corr_count", 32'(bi.corr_count), 32'd0);

    // Reset asserted in the middle of a fix discards it.
    do_reset();
    wr(3, 32'h00000055);
    inj(0, 3, 32'h000000F0);
    bi.ra1 = 3;
    bi.scrub_en = 1;
    wait_fix("rstfix fix");
    rst_n = 1'b0;
    #2;
    chk("rstfix rd1", bi.rd1, 32'h0);
    chk("rstfix scrub_addr", 32'(bi.scrub_addr), 32'd1);
    chk("rstfix corr_count", 32'(bi.corr_count), 32'd0);
    chk("rstfix multi_fault", 32'(bi.multi_fault), 32'd0);
    bi.scrub_en = 0;
    tick();
    rst_n = 1'b1;
    tick(2);
    chk("rstfix post rd1", bi.rd1, 32'h0);
    chk("rstfix post corr_count", 32'(bi.corr_count), 32'd0);

    // Pointer walks 1..31 and wraps to 1, never 0.
    do_reset();
    bi.scrub_en = 1;
    tick();
    chk("wrap start", 32'(bi.scrub_addr), 32'd1);
    tick(30);
    chk("wrap top", 32'(bi.scrub_addr), 32'd31);
    tick();
    chk("wrap back", 32'(bi.scrub_addr), 32'd1);

    // Five corrections on a 2-bit counter saturate at 3.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bs.we3 = 1; bs.wa3 = 5'(2 + 2 * k); bs.wd3 = 32'h1000 + 32'(k);
      tick();
      bs.we3 = 0;
      bs.inj_en = 1; bs.inj_copy = 2'(k % 3); bs.inj_addr = 5'(2 + 2 * k); bs.inj_mask = 32'h1 << k;
      tick();
      bs.inj_en = 0;
    end
    bs.ra1 = 10;
    #1;
    chk("sat rd1 voted", bs.rd1, 32'h00001004);
    bs.scrub_en = 1;
    tick(45);
    chk("sat corr_count", 32'(bs.corr_count), 32'd3);
    chk("sat r10 c1", dut_s.c1[10], 32'h00001004);
    chk("sat r2 c0", dut_s.c0[2], 32'h00001000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
